// File: rtl/pipeline_control.sv
`timescale 1ns/1ps
// pipeline_control
// Central sequencer for the five-stage MIPS pipeline. Holds the debug
// run/step/halt mode, decodes per-cycle PC and stage enables plus the
// stage flushes for load-use stalls and branches resolved in MEM, and
// counts enabled cycles for the debug unit.
//
// Debug commands (i_start, i_step, i_stop) are single-cycle pulses with no
// handshake: a pulse is sampled at the next rising edge and its effect is
// visible on the outputs in the following cycle. Pulses that the current
// mode does not accept are simply dropped.
module pipeline_control #(
    parameter int NB_REG = 5,
    parameter int NB_CNT = 32
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_step,
    input  logic              i_stop,
    input  logic              i_WB_halt,
    input  logic              i_ID_EX_mem_read,
    input  logic [NB_REG-1:0] i_ID_EX_rt,
    input  logic [NB_REG-1:0] i_IF_ID_rs,
    input  logic [NB_REG-1:0] i_IF_ID_rt,
    input  logic              i_MEM_branch_taken,
    output logic              o_pc_enable,
    output logic              o_pc_src,
    output logic              o_stage_enable,
    output logic              o_IF_ID_write,
    output logic              o_IF_ID_flush,
    output logic              o_ID_EX_flush,
    output logic              o_EX_MEM_flush,
    output logic [1:0]        o_state,
    output logic              o_halted,
    output logic [NB_CNT-1:0] o_cycle_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [NB_CNT-1:0] cycle_count;
    logic              en;
    logic              load_use;
    logic              branch;

    // The pipeline only advances while free-running or during a single step.
    assign en       = (state == ST_RUN) || (state == ST_STEP);
    // A load in EX whose destination (other than $zero) feeds the instruction in ID.
    assign load_use = en && i_ID_EX_mem_read && (i_ID_EX_rt != '0) &&
                      ((i_ID_EX_rt == i_IF_ID_rs) || (i_ID_EX_rt == i_IF_ID_rt));
    assign branch   = en && i_MEM_branch_taken;

    // Mode register; reset wins over every command.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Mode transitions driven by debug commands and the HALT instruction reaching WB.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (i_stop) begin
                    state_next = ST_IDLE;
                end else if (i_start) begin
                    state_next = ST_RUN;
                end else if (i_step) begin
                    state_next = ST_STEP;
                end
            end
            ST_RUN: begin
                if (i_WB_halt) begin
                    state_next = ST_HALTED;
                end else if (i_stop) begin
                    state_next = ST_IDLE;
                end
            end
            ST_STEP: begin
                state_next = i_WB_halt ? ST_HALTED : ST_IDLE;
            end
            ST_HALTED: begin
                state_next = ST_HALTED;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Enable/flush decode: a taken branch squashes the three younger stages and
    // overrides any stall; otherwise a load-use hazard holds PC and IF/ID for
    // one cycle and injects a bubble into ID/EX.
    always_comb begin
        o_pc_enable    = 1'b0;
        o_pc_src       = 1'b0;
        o_IF_ID_write  = 1'b0;
        o_IF_ID_flush  = 1'b0;
        o_ID_EX_flush  = 1'b0;
        o_EX_MEM_flush = 1'b0;
        if (branch) begin
            o_pc_enable    = 1'b1;
            o_pc_src       = 1'b1;
            o_IF_ID_write  = 1'b1;
            o_IF_ID_flush  = 1'b1;
            o_ID_EX_flush  = 1'b1;
            o_EX_MEM_flush = 1'b1;
        end else if (load_use) begin
            o_ID_EX_flush  = 1'b1;
        end else begin
            o_pc_enable    = en;
            o_IF_ID_write  = en;
        end
    end

    // Executed-cycle counter: counts every enabled cycle, stalls included,
    // and sticks at all-ones rather than wrapping.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            cycle_count <= '0;
        end else if (en && (cycle_count != '1)) begin
            cycle_count <= cycle_count + {{(NB_CNT-1){1'b0}}, 1'b1};
        end
    end

    assign o_stage_enable = en;
    assign o_state        = state;
    assign o_halted       = (state == ST_HALTED);
    assign o_cycle_count  = cycle_count;

endmodule

// File: tb/tb_pipeline_control.sv
`timescale 1ns/1ps
// tb_pipeline_control
// Randomized and directed stimulus for pipeline_control. A driver applies one
// cycle of inputs at a time and pushes the response predicted by a
// behavioural model; a monitor pops and compares each cycle.
module tb_pipeline_control;

    localparam int RW      = 5;
    localparam int CW      = 8;
    localparam int EW      = 10 + CW;
    localparam int CNT_MAX = (1 << CW) - 1;

    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_STEP   = 2;
    localparam int M_HALTED = 3;

    // clock / reset
    logic          clock = 1'b0;
    logic          reset;
    logic          start, step, stop, wb_halt, mem_read, br_taken;
    logic [RW-1:0] ex_rt, id_rs, id_rt;

    logic          pc_enable, pc_src, stage_enable, if_id_write;
    logic          if_id_flush, id_ex_flush, ex_mem_flush, halted;
    logic [1:0]    state;
    logic [CW-1:0] cycle_count;

    always #5 clock = ~clock;

    pipeline_control #(.NB_REG(RW), .NB_CNT(CW)) dut (
        .i_clock            (clock),
        .i_reset            (reset),
        .i_start            (start),
        .i_step             (step),
        .i_stop             (stop),
        .i_WB_halt          (wb_halt),
        .i_ID_EX_mem_read   (mem_read),
        .i_ID_EX_rt         (ex_rt),
        .i_IF_ID_rs         (id_rs),
        .i_IF_ID_rt         (id_rt),
        .i_MEM_branch_taken (br_taken),
        .o_pc_enable        (pc_enable),
        .o_pc_src           (pc_src),
        .o_stage_enable     (stage_enable),
        .o_IF_ID_write      (if_id_write),
        .o_IF_ID_flush      (if_id_flush),
        .o_ID_EX_flush      (id_ex_flush),
        .o_EX_MEM_flush     (ex_mem_flush),
        .o_state            (state),
        .o_halted           (halted),
        .o_cycle_count      (cycle_count)
    );

    // scoreboard
    logic [EW-1:0] exp_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;

    // behavioural model state
    int m_state;
    int m_count;

    // One clock of stimulus: drive inputs, predict this cycle's outputs,
    // then advance the model to what the next edge should produce.
    task automatic cycle(input logic rst, input logic c_start, input logic c_step,
                         input logic c_stop, input logic halt, input logic mr,
                         input logic [RW-1:0] ert, input logic [RW-1:0] rs,
                         input logic [RW-1:0] rt, input logic bt);
        bit en, lu, br;
        logic [1:0] st;
        @(negedge clock);
        reset = rst; start = c_start; step = c_step; stop = c_stop;
        wb_halt = halt; mem_read = mr; ex_rt = ert; id_rs = rs; id_rt = rt;
        br_taken = bt;

        en = (m_state == M_RUN) || (m_state == M_STEP);
        lu = en && mr && (ert != 0) && ((ert == rs) || (ert == rt));
        br = en && bt;
        st = m_state[1:0];
        exp_q.push_back({st, (m_state == M_HALTED),
                         br || (en && !lu),   // pc_enable
                         br,                  // pc_src
                         en,                  // stage_enable
                         br || (en && !lu),   // IF_ID_write
                         br,                  // IF_ID_flush
                         br || lu,            // ID_EX_flush
                         br,                  // EX_MEM_flush
                         m_count[CW-1:0]});

        if (rst) begin
            m_state = M_IDLE;
            m_count = 0;
        end else begin
            if (en && m_count < CNT_MAX) m_count = m_count + 1;
            case (m_state)
                M_IDLE: begin
                    if (c_stop) m_state = M_IDLE;
                    else if (c_start) m_state = M_RUN;
                    else if (c_step) m_state = M_STEP;
                end
                M_RUN: begin
                    if (halt) m_state = M_HALTED;
                    else if (c_stop) m_state = M_IDLE;
                end
                M_STEP: m_state = halt ? M_HALTED : M_IDLE;
                default: m_state = M_HALTED;
            endcase
        end
    endtask

    task automatic quiet();
        cycle(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    endtask

    // Cycles with random hazard inputs and no commands; small register
    // indices make load-use matches frequent.
    task automatic hazard_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(0, 0, 0, 0, 0, 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
        end
    endtask

    task automatic do_reset();
        cycle(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    endtask

    // monitor: compare every cycle the driver has a prediction for
    initial begin
        logic [EW-1:0] e;
        logic [EW-1:0] got;
        forever begin
            @(negedge clock);
            #2;
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                got = {state, halted, pc_enable, pc_src, stage_enable, if_id_write,
                       if_id_flush, id_ex_flush, ex_mem_flush, cycle_count};
                n_checks++;
                if (got[EW-1:CW] !== e[EW-1:CW]) begin
                    n_fail++;
                    $display("FAIL ctrl t=%0t got st/halt/pcen/src/stg/ifw/fl3=%b required=%b",
                             $time, got[EW-1:CW], e[EW-1:CW]);
                end
                n_checks++;
                if (got[CW-1:0] !== e[CW-1:0]) begin
                    n_fail++;
                    $display("FAIL count t=%0t got=%0d required=%0d",
                             $time, got[CW-1:0], e[CW-1:0]);
                end
            end
        end
    end

    // watchdog
    initial begin
        #500000;
        n_fail++;
        $display("FAIL timeout t=%0t bench did not complete", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "timeout");
    end

    // driver
    initial begin
        reset = 1'b1; start = 0; step = 0; stop = 0; wb_halt = 0;
        mem_read = 0; br_taken = 0; ex_rt = '0; id_rs = '0; id_rt = '0;
        repeat (2) @(posedge clock);
        m_state = M_IDLE;
        m_count = 0;

        // 1: reset state, start, 10 run cycles, stop, count holds
        quiet();
        quiet();
        cycle(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        repeat (10) quiet();
        cycle(0, 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        repeat (3) quiet();

        // 2: three single steps from IDLE (with a stray halt in IDLE)
        do_reset();
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
            repeat (3) quiet();
        end
        cycle(0, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
        quiet();

        // 3: load-use stalls in RUN; rt==0 must not stall
        cycle(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        cycle(0, 0, 0, 0, 0, 1, 5'd8, 5'd8, 5'd3, 0);
        quiet();
        cycle(0, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0);
        cycle(0, 0, 0, 0, 0, 1, 5'd9, 5'd2, 5'd9, 0);
        cycle(0, 0, 0, 0, 0, 0, 5'd9, 5'd9, 5'd9, 0);

        // 4: branch together with load-use
        cycle(0, 0, 0, 0, 0, 1, 5'd8, 5'd8, 5'd8, 1);
        cycle(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1);

        // 5: halt beats stop; commands ignored while halted; hazards masked
        cycle(0, 0, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0);
        cycle(0, 1, 0, 0, 0, 1, 5'd4, 5'd4, 5'd4, 1);
        cycle(0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1);
        cycle(0, 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        quiet();

        // 6: reset mid-RUN at count 5; start+stop together in IDLE; step into halt
        do_reset();
        cycle(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        repeat (5) quiet();
        cycle(1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1);
        cycle(0, 1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        quiet();
        cycle(0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        cycle(0, 1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
        quiet();
        cycle(0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        cycle(1, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        quiet();

        // counter saturation over a long run
        cycle(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        hazard_cycles(CNT_MAX + 12);
        cycle(0, 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        repeat (2) quiet();

        // fully random commands, hazards, halts and resets
        do_reset();
        for (int i = 0; i < 800; i++) begin
            cycle(($urandom_range(0, 59) == 0),
                  ($urandom_range(0, 11) == 0),
                  ($urandom_range(0, 11) == 0),
                  ($urandom_range(0, 23) == 0),
                  ($urandom_range(0, 39) == 0),
                  1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
        end
        quiet();

        repeat (3) @(negedge clock);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got=%0d pending required=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_control.md
Name: pipeline_control

Overview:
Central sequencer for the five-stage MIPS pipeline (IF, IF/ID, ID/EX, EX/MEM, MEM/WB). Drives the global run/step/halt mode requested by the debug unit. Generates per-cycle PC/stage enables and stage flushes for load-use stalls and for branches resolved in MEM. Keeps an executed-cycle counter that the debug unit reads back.

Parameters:
NB_REG, 5, register-index width
NB_CNT, 32, cycle counter width

Ports:
i_clock  in  1  system clock
i_reset  in  1  synchronous active-high reset
i_start  in  1  debug cmd: free-run (1-cycle pulse)
i_step  in  1  debug cmd: advance exactly one clock (1-cycle pulse)
i_stop  in  1  debug cmd: pause to IDLE (1-cycle pulse)
i_WB_halt  in  1  HALT instruction is in WB this cycle
i_ID_EX_mem_read  in  1  instruction in EX is a load
i_ID_EX_rt  in  NB_REG  load destination register
i_IF_ID_rs  in  NB_REG  rs of instruction in ID
i_IF_ID_rt  in  NB_REG  rt of instruction in ID
i_MEM_branch_taken  in  1  MEM_branch AND MEM_zero
o_pc_enable  out  1  PC register write enable
o_pc_src  out  1  1 = PC loads MEM_branch_address
o_stage_enable  out  1  write enable for all pipeline registers
o_IF_ID_write  out  1  IF/ID write enable
o_IF_ID_flush  out  1  IF/ID loads NOP
o_ID_EX_flush  out  1  ID/EX control fields forced to 0 (bubble)
o_EX_MEM_flush  out  1  EX/MEM control fields forced to 0
o_state  out  2  0 IDLE, 1 RUN, 2 STEP, 3 HALTED
o_halted  out  1  program finished
o_cycle_count  out  NB_CNT  enabled cycles since reset

Behaviour:
- Reset: state=IDLE, o_cycle_count=0. All enables, flushes, o_pc_src and o_halted are 0.
- FSM is Moore, registered state. Outputs decode from the current state plus the hazard inputs, so a command sampled at edge N affects outputs from cycle N+1.
- IDLE: i_stop beats i_start, which beats i_step. i_start -> RUN. i_step -> STEP. Otherwise stay.
- RUN: i_WB_halt -> HALTED (beats i_stop). i_stop -> IDLE. i_start and i_step are ignored.
- STEP: lasts exactly one cycle. Next state is HALTED if i_WB_halt, else IDLE. All commands are ignored.
- HALTED: o_halted=1 and all enables are 0. Leaves only on i_reset. All commands are ignored.
- en = (state==RUN || state==STEP). o_stage_enable = en.
- Load-use hazard: lu = en && i_ID_EX_mem_read && i_ID_EX_rt!=0 && (i_ID_EX_rt==i_IF_ID_rs || i_ID_EX_rt==i_IF_ID_rt).
- Branch: br = en && i_MEM_branch_taken.
- If br: o_pc_src=1, o_pc_enable=1, o_IF_ID_write=1. Also o_IF_ID_flush=o_ID_EX_flush=o_EX_MEM_flush=1. Branch wins over lu, and lu flushes are suppressed.
- Else if lu: o_pc_enable=0, o_IF_ID_write=0, o_ID_EX_flush=1. Other flushes are 0. One bubble per occurrence; the hazard clears naturally the next cycle.
- Else: o_pc_enable=o_IF_ID_write=en, all flushes 0, o_pc_src=0.
- When en=0, every enable, flush and o_pc_src is 0 regardless of hazard inputs.
- Counter increments by 1 on every cycle with en=1, stalled cycles included. It saturates at all-ones and freezes in IDLE and HALTED.
- i_reset asserted in any state (mid-RUN, mid-STEP) takes effect at the next edge and overrides all other inputs.
- i_WB_halt asserted while in IDLE is ignored.

Test Plan:
1. Reset, then i_start pulse at cycle 2 -> o_state=1 and o_stage_enable=1 from cycle 3. After 10 RUN cycles, o_cycle_count=10. i_stop pulse -> IDLE next cycle, count holds at 10.
2. From IDLE, three i_step pulses spaced 4 cycles apart -> o_stage_enable high for exactly 1 cycle each, state returns to 0, o_cycle_count=3.
3. In RUN with i_ID_EX_mem_read=1, i_ID_EX_rt=8, i_IF_ID_rs=8 for 1 cycle -> that cycle o_pc_enable=0, o_IF_ID_write=0, o_ID_EX_flush=1. Repeat with rt=0 -> no stall.
4. In RUN: i_MEM_branch_taken=1 together with the load-use condition -> o_pc_src=1, o_pc_enable=1, all three flushes 1 in that cycle.
5. In RUN: i_WB_halt=1 and i_stop=1 in the same cycle -> next state HALTED, o_halted=1, enables 0. Subsequent i_start and i_step are ignored, and the counter is frozen.
6. i_reset during RUN with count=5 -> next cycle state=IDLE, count=0. Also: i_start and i_stop together in IDLE -> stays IDLE.
